// File: rtl/inmultitor_8b_secvential.sv
// ============================================================================
// Module   : inmultitor_8b_secvential
// Purpose  : Sequential 8x8 unsigned shift-and-add multiplier (16-bit product)
//            that uses an external 8-bit adder as its only arithmetic unit.
//            Optional macro INMULTITOR_START_ERR_EN adds a sticky start_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inmultitor_8b_secvential #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_in0,
  output logic [WIDTH-1:0]   add_in1,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
`ifdef INMULTITOR_START_ERR_EN
  ,
  output logic               start_err
`endif
);

  generate
    if (WIDTH != 8) begin : g_width_check
      $error("inmultitor_8b_secvential: WIDTH must be 8 to match the adder");
    end
  endgenerate

  localparam int           c_CNT_W     = 4;
  localparam [c_CNT_W-1:0] c_LAST_ITER = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_q;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_shifted;

  // Next {acc, q}: adder result with carry on top, multiplier shifted right.
  assign w_shifted = {add_cout, add_sum, r_q[WIDTH-1:1]};
  assign product   = r_product;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    add_in0      = '0;
    add_in1      = '0;
    add_cin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_CALC;
        end
      end
      S_CALC: begin
        busy    = 1'b1;
        add_in0 = r_acc;
        add_in1 = r_q[0] ? r_mcand : '0;
        if (r_cnt == c_LAST_ITER) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= op_a;
            r_q     <= op_b;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          {r_acc, r_q} <= w_shifted;
          r_cnt        <= r_cnt + 4'd1;
          // Product is captured on the final iteration so it is valid with done.
          if (r_cnt == c_LAST_ITER) begin
            r_product <= w_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef INMULTITOR_START_ERR_EN
  logic r_start_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_err <= 1'b0;
    end else if (start && busy) begin
      r_start_err <= 1'b1;
    end
  end

  assign start_err = r_start_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inmultitor_8b_secvential.sv
// Self-checking bench for inmultitor_8b_secvential with a behavioural adder
// and an arithmetic reference model of the partial products.
`default_nettype none

module tb_inmultitor_8b_secvential;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  add_in0;
  logic [7:0]  add_in1;
  logic        add_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
`ifdef INMULTITOR_START_ERR_EN
  logic        start_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Downstream 8-bit adder stage.
  assign {add_cout, add_sum} = {1'b0, add_in0} + {1'b0, add_in1} + {8'd0, add_cin};

  inmultitor_8b_secvential #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_in0  (add_in0),
    .add_in1  (add_in1),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
`ifdef INMULTITOR_START_ERR_EN
    ,
    .start_err(start_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge with the DUT idle. Leaves the bench in the
  // first IDLE cycle after done.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input bit hold);
    int unsigned partial;
    int unsigned exp_prod;
    exp_prod = int'(a) * int'(b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      // Operand changes after acceptance must not matter.
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      partial = int'(a) * (int'(b) % (1 << i));
      chk($sformatf("busy_it%0d", i), {31'd0, busy}, 32'd1);
      chk($sformatf("done_it%0d", i), {31'd0, done}, 32'd0);
      chk($sformatf("cin_it%0d", i), {31'd0, add_cin}, 32'd0);
      chk($sformatf("in0_it%0d", i), {24'd0, add_in0}, partial >> i);
      chk($sformatf("in1_it%0d", i), {24'd0, add_in1}, b[i] ? {24'd0, a} : 32'd0);
      step();
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd1);
    chk("product", {16'd0, product}, exp_prod);
    chk("in1_done", {24'd0, add_in1}, 32'd0);
    step();
    chk("done_after", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("product_held", {16'd0, product}, exp_prod);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    op_a  = 8'h55;
    op_b  = 8'hAA;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_in0", {24'd0, add_in0}, 32'd0);
    chk("rst_in1", {24'd0, add_in1}, 32'd0);
    chk("rst_cin", {31'd0, add_cin}, 32'd0);
`ifdef INMULTITOR_START_ERR_EN
    chk("rst_start_err", {31'd0, start_err}, 32'd0);
`endif
    reset = 1'b0;
    start = 1'b0;
    step();

    run_mul(8'h0F, 8'h0F, 1'b0);
    run_mul(8'hFF, 8'hFF, 1'b0);
    run_mul(8'hAB, 8'h00, 1'b0);

    // Reset during the 4th iteration aborts without exposing a result.
    op_a  = 8'h12;
    op_b  = 8'h34;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'd0);
    begin
      int seen_done = 0;
      for (int i = 0; i < 10; i++) begin
        if (done) seen_done++;
        step();
      end
      chk("abort_no_done", seen_done, 32'd0);
    end
    run_mul(8'h12, 8'h34, 1'b0);

    // Back-to-back with start held: second start taken in the first IDLE cycle.
    run_mul(8'h80, 8'h02, 1'b1);
    run_mul(8'h10, 8'h10, 1'b1);
    start = 1'b0;
    step();
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    for (int n = 0; n < 20; n++) begin
      run_mul(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      start = 1'b0;
      step();
    end

`ifdef INMULTITOR_START_ERR_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("serr_clear", {31'd0, start_err}, 32'd0);
    run_mul(8'h21, 8'h03, 1'b0);
    chk("serr_no_busy_start", {31'd0, start_err}, 32'd0);
    op_a  = 8'h07;
    op_b  = 8'h09;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("serr_set", {31'd0, start_err}, 32'd1);
    for (int i = 0; i < 8; i++) step();
    chk("serr_sticky", {31'd0, start_err}, 32'd1);
    chk("serr_product", {16'd0, product}, 32'd63);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("serr_reset", {31'd0, start_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
